// File: rtl/ram_dump_streamer.sv
// Walks every RAM address in order after a halt and streams {address, data}
// words to a sink over a valid/ready handshake, one RAM read per word.
module ram_dump_streamer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ONE       = 1;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   count;
  logic                    xfer;
  logic                    launch;

  assign xfer   = m_valid && m_ready;
  assign launch = ((state == IDLE) || (state == DONE)) && start;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    ram_rd_en = 1'b0;
    m_valid   = 1'b0;
    ram_addr  = count;
    case (state)
      IDLE: if (start) state_nxt = READ;
      READ: begin
        busy      = 1'b1;
        ram_rd_en = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        busy      = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        if (xfer) state_nxt = m_last ? DONE : READ;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = READ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The stream word is loaded only in WAIT, so later RAM writes cannot
  // disturb a word that is being held under backpressure.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count  <= '0;
      m_addr <= '0;
      m_data <= '0;
      m_last <= 1'b0;
    end else begin
      if (launch) begin
        count <= '0;
      end else if ((state == SEND) && xfer && !m_last) begin
        count <= count + ONE;
      end
      if (state == WAIT) begin
        m_data <= ram_rdata;
        m_addr <= count;
        m_last <= (count == LAST_ADDR);
      end
    end
  end

endmodule

// File: tb/tb_ram_dump_streamer.sv
// Bench for ram_dump_streamer: a registered-read RAM model, a table of dump
// scenarios checked against an expected word queue, plus a mid-dump reset.
module tb_ram_dump_streamer;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          ram_rd_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata;
  logic          m_valid;
  logic          m_ready;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_last;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } word_t;

  typedef struct {
    int fill;         // 0: 0x10+i, 1: LDA program image, 2: random bytes
    int stall_addr;   // address held under backpressure, -1 for none
    int stall_len;    // cycles of m_ready low at stall_addr
    int repulse_addr; // start re-pulsed while this address is in SEND, -1 none
    bit rand_ready;   // 50% random m_ready
    int exp_stalls;   // expected backpressure cycles, -1 when random
  } vec_t;

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] lda_image [DEPTH] = '{
    8'h1E, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAB, 8'h00
  };
  word_t exp_q [$];

  ram_dump_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ram_rd_en (ram_rd_en),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_addr    (m_addr),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  // Secondary RAM port: data appears one cycle after the read strobe.
  always @(posedge clk) if (ram_rd_en) ram_rdata <= ram[ram_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < DEPTH; i++) begin
      case (kind)
        0:       ram[i] = 8'h10 + 8'(i);
        1:       ram[i] = lda_image[i];
        default: ram[i] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  // Expected stream: every address once, in order, with last only at the top.
  task automatic build_expected();
    word_t w;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      w.a = AW'(i);
      w.d = ram[i];
      w.l = (i == DEPTH - 1);
      exp_q.push_back(w);
    end
  endtask

  task automatic run_dump(input int id, input vec_t v);
    word_t w;
    word_t held;
    bit    holding    = 1'b0;
    bit    just_xfer  = 1'b0;
    int    busy_cyc   = 0;
    int    stalls     = 0;
    int    first_val  = -1;
    int    stall_left = v.stall_len;
    int    guard      = 0;
    bit    repulsed   = 1'b0;

    fill(v.fill);
    build_expected();
    m_ready = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && guard < 2000) begin
      guard++;
      if (busy) busy_cyc++;
      if (m_valid && first_val < 0) first_val = busy_cyc;
      if (holding)
        check($sformatf("v%0d_hold_stable", id), {m_valid, m_addr, m_data, m_last}, {1'b1, held});
      if (just_xfer)
        check($sformatf("v%0d_valid_drop", id), m_valid, 1'b0);

      start = 1'b0;
      if (m_valid && int'(m_addr) == v.repulse_addr && !repulsed) begin
        start    = 1'b1;
        repulsed = 1'b1;
      end

      if (v.rand_ready) begin
        m_ready = 1'($urandom_range(0, 1));
      end else if (m_valid && int'(m_addr) == v.stall_addr && stall_left > 0) begin
        if (stall_left == v.stall_len) ram[m_addr] = ~ram[m_addr];
        stall_left--;
        m_ready = 1'b0;
      end else begin
        m_ready = 1'b1;
      end
      if (m_valid && !m_ready) stalls++;

      just_xfer = m_valid && m_ready;
      if (just_xfer) begin
        check($sformatf("v%0d_word_expected", id), exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check($sformatf("v%0d_word_a%0d", id, w.a), {m_addr, m_data, m_last}, w);
        end
        if (v.fill == 1 && m_addr == 4'hE)
          check($sformatf("v%0d_lda_result", id), m_data, 8'hAB);
      end
      holding = m_valid && !m_ready;
      held    = {m_addr, m_data, m_last};
      @(negedge clk);
    end
    start = 1'b0;
    check($sformatf("v%0d_done_reached", id), done, 1'b1);
    check($sformatf("v%0d_busy_after", id), busy, 1'b0);
    check($sformatf("v%0d_valid_after", id), m_valid, 1'b0);
    check($sformatf("v%0d_words_left", id), exp_q.size(), 0);
    check($sformatf("v%0d_first_valid", id), first_val, 3);
    check($sformatf("v%0d_busy_cycles", id), busy_cyc, 3 * DEPTH + stalls);
    if (v.exp_stalls >= 0)
      check($sformatf("v%0d_stalls", id), stalls, v.exp_stalls);
    repeat (2) @(negedge clk);
    check($sformatf("v%0d_done_held", id), {done, busy, ram_rd_en}, 3'b100);
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{fill: 0, stall_addr: -1, stall_len: 0, repulse_addr: -1, rand_ready: 1'b0, exp_stalls: 0};
    vecs[1] = '{fill: 1, stall_addr: -1, stall_len: 0, repulse_addr: -1, rand_ready: 1'b0, exp_stalls: 0};
    vecs[2] = '{fill: 0, stall_addr: 3,  stall_len: 5, repulse_addr: -1, rand_ready: 1'b0, exp_stalls: 5};
    vecs[3] = '{fill: 2, stall_addr: -1, stall_len: 0, repulse_addr: 7,  rand_ready: 1'b0, exp_stalls: 0};
    vecs[4] = '{fill: 2, stall_addr: -1, stall_len: 0, repulse_addr: -1, rand_ready: 1'b1, exp_stalls: -1};
    vecs[5] = '{fill: 0, stall_addr: -1, stall_len: 0, repulse_addr: -1, rand_ready: 1'b1, exp_stalls: -1};

    reset   = 1'b0;
    start   = 1'b0;
    m_ready = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, ram_rd_en, ram_addr, m_valid, m_addr, m_data, m_last}, '0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_start", {busy, done, m_valid}, 3'b000);

    for (int i = 0; i < 4; i++) run_dump(i, vecs[i]);

    // Reset while address 9 is held in SEND.
    fill(0);
    m_ready = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int g = 0; g < 200 && !(m_valid && m_addr == 4'd9); g++) @(negedge clk);
    m_ready = 1'b0;
    check("rst_reached_a9", {m_valid, m_addr}, {1'b1, 4'd9});
    @(negedge clk);
    check("rst_still_a9", {m_valid, m_addr, m_data}, {1'b1, 4'd9, 8'h19});
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_dump", {m_valid, busy, done, ram_rd_en, m_data, m_addr, m_last}, '0);
    reset   = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    check("rst_release_idle", {busy, done, m_valid}, 3'b000);

    for (int i = 4; i < 6; i++) run_dump(i, vecs[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
